// File: rtl/rtc_bus_pkg.sv
// Shared encodings for the RTC parallel-bus sequencer: phase states, op codes,
// idle strobe levels and the per-state bus level table.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_A_SET = 4'd1,
    ST_A_STB = 4'd2,
    ST_A_HLD = 4'd3,
    ST_GAP   = 4'd4,
    ST_D_SET = 4'd5,
    ST_D_STB = 4'd6,
    ST_D_HLD = 4'd7,
    ST_DONE  = 4'd8
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam logic STB_IDLE          = 1'b1;
  localparam int   DEFAULT_PHASE_CYC = 4;

  typedef struct packed {
    logic       ado;
    logic       cso;
    logic       rdo;
    logic       wro;
    logic       oe;
    logic [7:0] ad;
  } bus_t;

  function automatic state_e next_phase(input state_e st);
    state_e nxt;
    case (st)
      ST_A_SET: nxt = ST_A_STB;
      ST_A_STB: nxt = ST_A_HLD;
      ST_A_HLD: nxt = ST_GAP;
      ST_GAP:   nxt = ST_D_SET;
      ST_D_SET: nxt = ST_D_STB;
      ST_D_STB: nxt = ST_D_HLD;
      ST_D_HLD: nxt = ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Bus levels to present while in a given state; the address is always
  // strobed with WR, and only a write drives the pad during the data half.
  function automatic bus_t bus_levels(input state_e st, input op_e op,
                                      input logic [7:0] addr, input logic [7:0] data);
    bus_t b;
    b.ado = STB_IDLE;
    b.cso = STB_IDLE;
    b.rdo = STB_IDLE;
    b.wro = STB_IDLE;
    b.oe  = 1'b0;
    b.ad  = 8'h00;
    case (st)
      ST_A_SET, ST_A_STB, ST_A_HLD: begin
        b.cso = 1'b0;
        b.ado = 1'b0;
        b.oe  = 1'b1;
        b.ad  = addr;
        if (st == ST_A_STB) b.wro = 1'b0;
      end
      ST_GAP: begin
        b.oe = (op == OP_WR);
        b.ad = (op == OP_WR) ? data : 8'h00;
      end
      ST_D_SET, ST_D_STB, ST_D_HLD: begin
        b.cso = 1'b0;
        b.oe  = (op == OP_WR);
        b.ad  = (op == OP_WR) ? data : 8'h00;
        if (st == ST_D_STB) begin
          if (op == OP_WR) b.wro = 1'b0;
          else             b.rdo = 1'b0;
        end
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; expire is high while the count is zero.
module rtc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_value;
    else if (r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates write/read requesters onto the RTC multiplexed bus and runs one
// address+data cycle per grant. Define RTC_RR_ARB_EN for round-robin arbitration.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = DEFAULT_PHASE_CYC,
  parameter int CNT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  input  logic [7:0] AdressDatai,
  output logic       ad_oe,
  output logic       ADo,
  output logic       CSo,
  output logic       RDo,
  output logic       WRo,
  output logic [7:0] AdressDatao
);

  localparam logic [CNT_W-1:0] PHASE_LD = CNT_W'(PHASE_CYC - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  op_e        r_op;
  op_e        w_op_nxt;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_rd_cap;
  logic [7:0] w_addr_nxt;
  logic [7:0] w_data_nxt;
  logic       w_grant;
  logic       w_grant_wr;
  logic       w_phased;
  logic       w_expire;
  logic       w_load;
  bus_t       w_bus_nxt;

  assign w_grant  = (r_state == ST_IDLE) && (wr_req || rd_req);
  assign w_phased = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_load   = w_grant || (w_phased && w_expire);

`ifdef RTC_RR_ARB_EN
  // Remembers whether the last grant went to the writer; cleared so a first tie goes to write.
  logic r_last_wr;

  assign w_grant_wr = wr_req && (!rd_req || !r_last_wr);

  always_ff @(posedge clock) begin
    if (reset)        r_last_wr <= 1'b0;
    else if (w_grant) r_last_wr <= w_grant_wr;
  end
`else
  assign w_grant_wr = wr_req;
`endif

  rtc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_value  (PHASE_LD),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant)                    w_state_nxt = ST_A_SET;
    else if (r_state == ST_DONE)    w_state_nxt = ST_IDLE;
    else if (w_phased && w_expire)  w_state_nxt = next_phase(r_state);
  end

  // On the grant edge the bus levels must already use the incoming request fields.
  assign w_op_nxt   = w_grant ? (w_grant_wr ? OP_WR : OP_RD) : r_op;
  assign w_addr_nxt = w_grant ? (w_grant_wr ? wr_addr : rd_addr) : r_addr;
  assign w_data_nxt = w_grant ? wr_data : r_data;
  assign w_bus_nxt  = bus_levels(w_state_nxt, w_op_nxt, w_addr_nxt, w_data_nxt);

  always_ff @(posedge clock) begin
    r_addr <= w_addr_nxt;
    r_data <= w_data_nxt;
    if ((r_state == ST_D_STB) && w_expire && (r_op == OP_RD))
      r_rd_cap <= AdressDatai;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_RD;
      ADo         <= STB_IDLE;
      CSo         <= STB_IDLE;
      RDo         <= STB_IDLE;
      WRo         <= STB_IDLE;
      ad_oe       <= 1'b0;
      AdressDatao <= 8'h00;
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= 8'h00;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      ADo         <= w_bus_nxt.ado;
      CSo         <= w_bus_nxt.cso;
      RDo         <= w_bus_nxt.rdo;
      WRo         <= w_bus_nxt.wro;
      ad_oe       <= w_bus_nxt.oe;
      AdressDatao <= w_bus_nxt.ad;
      busy        <= (w_state_nxt != ST_IDLE);
      wr_ack      <= (w_state_nxt == ST_DONE) && (r_op == OP_WR);
      rd_valid    <= (w_state_nxt == ST_DONE) && (r_op == OP_RD);
      if ((w_state_nxt == ST_DONE) && (r_op == OP_RD))
        rd_data <= r_rd_cap;
    end
  end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Owns the RTC chip's multiplexed parallel bus (ADo/CSo/RDo/WRo/AdressDatao) inside Controlador_RTC.
Shares the bus between two requesters:
- write port: the user-edit path driven by the BTN*/switchp logic
- read port: the periodic time/date refresh path
Each granted request runs as one complete address-phase + data-phase cycle with programmable strobe timing.
Returns a completion ack (write) or captured data (read).

Parameters:
PHASE_CYC, 4, clock cycles per bus phase (legal 1..255); at 10 ns clock gives 40 ns strobes
CNT_W, 8, width of phase counter; must hold PHASE_CYC-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_req  in  1  write request, level; held until wr_ack
wr_addr  in  8  RTC register address for write
wr_data  in  8  data to write
wr_ack  out  1  one-cycle pulse: write cycle complete
rd_req  in  1  read request, level; held until rd_valid
rd_addr  in  8  RTC register address for read
rd_data  out  8  captured read data, held until next read completes
rd_valid  out  1  one-cycle pulse: rd_data updated
busy  out  1  1 whenever state != IDLE
AdressDatai  in  8  bus value returned from pad
ad_oe  out  1  1 = drive AdressDatao onto pad
ADo  out  1  address/data select, 0 = address phase, idle 1
CSo  out  1  chip select, active low, idle 1
RDo  out  1  read strobe, active low, idle 1
WRo  out  1  write strobe, active low, idle 1
AdressDatao  out  8  multiplexed address/data out

Behaviour:
- Reset, applied at next clock edge: state=IDLE; ADo=CSo=RDo=WRo=1; ad_oe=0; AdressDatao=0; wr_ack=rd_valid=0; rd_data=0; busy=0; RR pointer favours write.
- Reset mid-cycle: abort immediately, no ack/valid issued, bus returns to idle levels on that edge.
- Outputs are registered.
- States, in order; each lasts PHASE_CYC cycles except IDLE and DONE.
  - IDLE: arbitrate. If any req=1, latch op/addr/data on this edge and go to A_SET.
  - A_SET: CSo=0, ADo=0, ad_oe=1, AdressDatao=addr.
  - A_STB: as A_SET, plus WRo=0 (address is always latched with WR).
  - A_HLD: WRo=1; CSo=0, ADo=0, addr still driven.
  - GAP: CSo=1, ADo=1, all strobes 1; ad_oe=1 for write, 0 for read.
  - D_SET: CSo=0, ADo=1; write: ad_oe=1, AdressDatao=data; read: ad_oe=0, AdressDatao=0.
  - D_STB: as D_SET, plus WRo=0 (write) or RDo=0 (read). Read samples AdressDatai into rd_data on the last D_STB cycle.
  - D_HLD: strobes 1, CSo=0, write data still driven.
  - DONE (1 cycle): idle bus levels; pulse wr_ack or rd_valid; next state IDLE.
- Latency: req sampled high in IDLE at edge t, ack/valid high in cycle t+7*PHASE_CYC+1 (29 for default).
- Back-to-back requests: minimum spacing is one IDLE cycle between transactions.
- Arbitration (default): fixed priority, write over read.
- Req held high in the cycle after ack counts as a new request.
- Req dropped before grant: ignored. Req dropped after grant: no effect, the cycle completes.
- A new request never starts while busy=1.
- Phase counter: loads PHASE_CYC-1 on state entry, decrements to 0, advances state at 0.
- PHASE_CYC=1 gives a single-cycle phase.

Optional Feature:
RTC_RR_ARB_EN
- Defined: round-robin arbitration. One-bit last_grant pointer; when both requests are pending in IDLE, grant the one not served last. Pointer updates on each grant; reset value makes write win the first tie.
- Undefined: fixed write-over-read priority; pointer logic absent.

Decomposition:
Package rtc_bus_pkg:
- state encoding constants (IDLE..DONE, 4-bit)
- strobe idle levels
- OP_RD/OP_WR codes
- default PHASE_CYC

One sub-module: rtc_phase_timer
- loadable down-counter, CNT_W wide
- inputs load/value; output expire

Test Plan:
- Write only: wr_req=1, wr_addr=0x21, wr_data=0x45 -> bus sequence matches the state table; WRo low exactly 4 cycles in each of A_STB and D_STB; wr_ack pulse at cycle 29; CSo high during GAP.
- Read only: rd_req=1, rd_addr=0x22, AdressDatai=0x37 during D_STB -> ad_oe=0 during GAP through D_HLD; RDo low 4 cycles; rd_data=0x37; rd_valid single pulse at cycle 29.
- Simultaneous requests, wr and rd both held high -> default: write served first, read starts after one IDLE cycle, read completes at cycle 59. RTC_RR_ARB_EN: order alternates W,R,W,R over 4 transactions.
- Reset asserted in D_STB of a write -> next edge: all strobes 1, ad_oe=0, busy=0, no wr_ack; a later request completes normally.
- PHASE_CYC=1 -> 8-cycle transaction, ack at cycle 8; request dropped before grant causes no bus activity.
